// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, requester ids, latched request.
// Combinational helpers only; no latency.
// No flow control of its own.
package mips_mem_pkg;

    localparam int unsigned MEM_WORDS_DFLT = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        req_id_t     id;
    } req_t;

    // Full 30-bit word index is compared so high addresses never alias into the array.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way picker between IF and D: round-robin (ARB_MODE 0) or D-priority (ARB_MODE 1).
// Grants are combinational in the cycle en is high; pointer updates on the clock edge.
// Losing requester simply sees no grant and keeps its request raised.
module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    req_id_t ptr;
    logic    both;

    assign both = if_req && d_req;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (en) begin
            if (both) begin
                if ((ARB_MODE == 1) || (ptr == REQ_D)) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    // Pointer only moves on contended grants and always lands on the loser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= REQ_D;
        end else if (en && both) begin
            ptr <= d_gnt ? REQ_IF : REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and load/store.
// Grant in IDLE, memory access the next cycle, registered rvalid/rdata the cycle after.
// One access per two cycles; a requester holds req until its gnt, no other backpressure.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DFLT,
    parameter int          ARB_MODE  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    arb_state_t state, state_nxt;
    req_t       lat;
    logic       lat_err;
    logic       pick_en;
    logic       resp_if;
    logic       resp_d;

    assign pick_en = (state == IDLE);
    assign lat_err = addr_bad(lat.addr, MEM_WORDS);
    assign resp_if = (state == ACCESS) && (lat.id == REQ_IF);
    assign resp_d  = (state == ACCESS) && (lat.id == REQ_D);

    mem_arb_pick #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pick_en),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    // Memory bus is driven only during ACCESS so a reset drops mem_we immediately.
    always_comb begin
        state_nxt = state;
        mem_a     = '0;
        mem_we    = 1'b0;
        mem_wd    = '0;
        if (state == ACCESS) begin
            mem_a     = lat.addr;
            mem_wd    = lat.wdata;
            mem_we    = lat.we && !lat_err;
            state_nxt = IDLE;
        end else if (if_gnt || d_gnt) begin
            state_nxt = ACCESS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat <= '0;
        end else if (d_gnt) begin
            lat <= '{addr: d_addr, wdata: d_wdata, we: d_we, id: REQ_D};
        end else if (if_gnt) begin
            lat <= '{addr: if_addr, wdata: 32'h0, we: 1'b0, id: REQ_IF};
        end
    end

    // rdata holds between responses; rvalid/err are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= resp_if;
            if_err    <= resp_if && lat_err;
            d_rvalid  <= resp_d;
            d_err     <= resp_d && lat_err;
            if (resp_if) begin
                if_rdata <= lat_err ? 32'h0 : mem_rd;
            end
            if (resp_d) begin
                d_rdata <= lat_err ? 32'h0 : mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus a reset-during-store sequence.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_a, mem_wd, mem_rd;
    logic        if_gnt1, if_rvalid1, if_err1, d_gnt1, d_rvalid1, d_err1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_a1, mem_wd1, mem_rd1;

    logic [31:0] mem  [0:63];
    logic [31:0] mem1 [0:63];
    logic        mem_init;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_WORDS(64), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_port_arbiter #(.MEM_WORDS(64), .ARB_MODE(1)) dut_prio (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1),
        .if_rdata(if_rdata1), .if_err(if_err1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt1),
        .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_a(mem_a1), .mem_we(mem_we1), .mem_wd(mem_wd1), .mem_rd(mem_rd1)
    );

    // Out-of-range reads return a non-zero pattern so forced-zero rdata is visible.
    assign mem_rd  = (mem_a[31:8]  == 24'h0) ? mem[mem_a[7:2]]   : 32'h0BAD0BAD;
    assign mem_rd1 = (mem_a1[31:8] == 24'h0) ? mem1[mem_a1[7:2]] : 32'h0BAD0BAD;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) begin
                mem[k]  <= (k == 2) ? 32'h2067fff7 : 32'h1000_0000 + k;
                mem1[k] <= (k == 2) ? 32'h2067fff7 : 32'h1000_0000 + k;
            end
        end else begin
            if (mem_we && mem_a[31:8] == 24'h0)
                mem[mem_a[7:2]] <= mem_wd;
            if (mem_we1 && mem_a1[31:8] == 24'h0)
                mem1[mem_a1[7:2]] <= mem_wd1;
        end
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_ifg;
        logic        e_dg;
        logic        e_ifg1;
        logic        e_dg1;
        logic [31:0] e_ma;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_ivld;
        logic [31:0] e_ird;
        logic        e_ierr;
        logic        e_dvld;
        logic [31:0] e_drd;
        logic        e_derr;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        //           ifr ifa       dr dwe da         dwd           ifg dg ifg1 dg1 mem_a     we wd            ivld ird           ierr dvld drd           derr
        tbl[0]  = '{1, 32'h08, 0, 0, 32'h00,  32'h0,        1, 0, 1, 0, 32'h000, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0};
        tbl[1]  = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h008, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0};
        tbl[2]  = '{0, 32'h00, 1, 1, 32'h44,  32'hDEADBEEF, 0, 1, 0, 1, 32'h000, 0, 32'h0,        1, 32'h2067fff7, 0, 0, 32'h0,        0};
        tbl[3]  = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h044, 1, 32'hDEADBEEF, 0, 32'h2067fff7, 0, 0, 32'h0,        0};
        tbl[4]  = '{1, 32'h0C, 0, 0, 32'h00,  32'h0,        1, 0, 1, 0, 32'h000, 0, 32'h0,        0, 32'h2067fff7, 0, 1, 32'h10000011, 0};
        tbl[5]  = '{0, 32'h00, 1, 0, 32'h44,  32'h0,        0, 0, 0, 0, 32'h00C, 0, 32'h0,        0, 32'h2067fff7, 0, 0, 32'h10000011, 0};
        tbl[6]  = '{0, 32'h00, 1, 0, 32'h44,  32'h0,        0, 1, 0, 1, 32'h000, 0, 32'h0,        1, 32'h10000003, 0, 0, 32'h10000011, 0};
        tbl[7]  = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h044, 0, 32'h0,        0, 32'h10000003, 0, 0, 32'h10000011, 0};
        tbl[8]  = '{1, 32'h10, 1, 0, 32'h20,  32'h0,        0, 1, 0, 1, 32'h000, 0, 32'h0,        0, 32'h10000003, 0, 1, 32'hDEADBEEF, 0};
        tbl[9]  = '{1, 32'h10, 1, 0, 32'h20,  32'h0,        0, 0, 0, 0, 32'h020, 0, 32'h0,        0, 32'h10000003, 0, 0, 32'hDEADBEEF, 0};
        tbl[10] = '{1, 32'h10, 1, 0, 32'h20,  32'h0,        1, 0, 0, 1, 32'h000, 0, 32'h0,        0, 32'h10000003, 0, 1, 32'h10000008, 0};
        tbl[11] = '{1, 32'h10, 1, 0, 32'h20,  32'h0,        0, 0, 0, 0, 32'h010, 0, 32'h0,        0, 32'h10000003, 0, 0, 32'h10000008, 0};
        tbl[12] = '{1, 32'h10, 1, 0, 32'h20,  32'h0,        0, 1, 0, 1, 32'h000, 0, 32'h0,        1, 32'h10000004, 0, 0, 32'h10000008, 0};
        tbl[13] = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h020, 0, 32'h0,        0, 32'h10000004, 0, 0, 32'h10000008, 0};
        tbl[14] = '{0, 32'h00, 1, 1, 32'h42,  32'h12345678, 0, 1, 0, 1, 32'h000, 0, 32'h0,        0, 32'h10000004, 0, 1, 32'h10000008, 0};
        tbl[15] = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h042, 0, 32'h12345678, 0, 32'h10000004, 0, 0, 32'h10000008, 0};
        tbl[16] = '{0, 32'h00, 1, 1, 32'h100, 32'hCAFEF00D, 0, 1, 0, 1, 32'h000, 0, 32'h0,        0, 32'h10000004, 0, 1, 32'h0,        1};
        tbl[17] = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h100, 0, 32'hCAFEF00D, 0, 32'h10000004, 0, 0, 32'h0,        0};
        tbl[18] = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h000, 0, 32'h0,        0, 32'h10000004, 0, 1, 32'h0,        1};
        tbl[19] = '{0, 32'h00, 0, 0, 32'h00,  32'h0,        0, 0, 0, 0, 32'h000, 0, 32'h0,        0, 32'h10000004, 0, 0, 32'h0,        0};

        rst_n    = 1'b0;
        mem_init = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("reset if_gnt", if_gnt, 0);
        chk("reset d_gnt", d_gnt, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_a", mem_a, 0);
        chk("reset if_rvalid", if_rvalid, 0);
        chk("reset if_rdata", if_rdata, 0);
        chk("reset d_rvalid", d_rvalid, 0);
        chk("reset d_rdata", d_rdata, 0);
        chk("reset d_err", d_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].ifr, tbl[i].ifa, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
            @(negedge clk);
            chk($sformatf("row%0d if_gnt", i), if_gnt, tbl[i].e_ifg);
            chk($sformatf("row%0d d_gnt", i), d_gnt, tbl[i].e_dg);
            chk($sformatf("row%0d prio if_gnt", i), if_gnt1, tbl[i].e_ifg1);
            chk($sformatf("row%0d prio d_gnt", i), d_gnt1, tbl[i].e_dg1);
            chk($sformatf("row%0d mem_a", i), mem_a, tbl[i].e_ma);
            chk($sformatf("row%0d mem_we", i), mem_we, tbl[i].e_we);
            chk($sformatf("row%0d mem_wd", i), mem_wd, tbl[i].e_wd);
            chk($sformatf("row%0d if_rvalid", i), if_rvalid, tbl[i].e_ivld);
            chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].e_ird);
            chk($sformatf("row%0d if_err", i), if_err, tbl[i].e_ierr);
            chk($sformatf("row%0d d_rvalid", i), d_rvalid, tbl[i].e_dvld);
            chk($sformatf("row%0d d_rdata", i), d_rdata, tbl[i].e_drd);
            chk($sformatf("row%0d d_err", i), d_err, tbl[i].e_derr);
        end

        // Erroring stores must leave memory untouched.
        chk("mem word16 after misaligned store", mem[16], 32'h10000010);
        chk("mem word0 after out-of-range store", mem[0], 32'h10000000);
        chk("mem word17 after good store", mem[17], 32'hDEADBEEF);

        // Reset asserted while a store is in its ACCESS cycle.
        @(posedge clk);
        #1 drive(0, 32'h0, 1, 1, 32'h48, 32'h55AA55AA);
        @(negedge clk);
        chk("rst seq d_gnt", d_gnt, 1);
        @(posedge clk);
        #1 drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1 chk("rst seq mem_we before reset", mem_we, 1);
        rst_n = 1'b0;
        #1 chk("rst seq mem_we after reset", mem_we, 0);
        @(posedge clk);
        #1 chk("rst seq d_rvalid in reset", d_rvalid, 0);
        chk("rst seq word18 unchanged", mem[18], 32'h10000012);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst seq d_rvalid after release", d_rvalid, 0);
        @(posedge clk);
        #1 chk("rst seq word18 still unchanged", mem[18], 32'h10000012);
        drive(1, 32'h04, 1, 0, 32'h08, 32'h0);
        @(negedge clk);
        chk("rst seq first contended d_gnt", d_gnt, 1);
        chk("rst seq first contended if_gnt", if_gnt, 0);
        @(posedge clk);
        #1 drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst seq access mem_a", mem_a, 32'h08);
        @(negedge clk);
        chk("rst seq d_rvalid", d_rvalid, 1);
        chk("rst seq d_rdata", d_rdata, 32'h10000002 ^ 32'h10000002 ^ mem[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
